// File: rtl/image_processing_accelerator.sv
// image_processing_accelerator: two-channel round-robin BMP byte-stream processor.
// Pixel bytes get saturating add/subtract; header bytes and mode-11 words pass through unmodified.
module image_processing_accelerator #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            slv0_mode,
    input  logic                  slv0_data_valid,
    input  logic [COLOR_SIZE-1:0] slv0_proc_val,
    input  logic [DATA_WIDTH-1:0] slv0_data,
    output logic                  slv0_ready,
    input  logic [1:0]            slv1_mode,
    input  logic                  slv1_data_valid,
    input  logic [COLOR_SIZE-1:0] slv1_proc_val,
    input  logic [DATA_WIDTH-1:0] slv1_data,
    output logic                  slv1_ready,
    output logic                  mstr0_cmplt,
    input  logic                  mstr0_ready,
    output logic [DATA_WIDTH-1:0] mstr0_data,
    output logic [1:0]            mstr0_data_valid
);
    localparam int LANES = DATA_WIDTH / COLOR_SIZE;

    logic [1:0][1:0]            mode;
    logic [1:0]                 dv;
    logic [1:0][COLOR_SIZE-1:0] pv;
    logic [1:0][DATA_WIDTH-1:0] din;
    logic [1:0][31:0]           cnt_q, cnt_d, off_q, off_d;
    logic [1:0][1:0]            prev_q;
    logic [1:0]                 pend_q, pend_d, pend, evt, ok, rdy, xfer;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [1:0]                 valid_q, valid_d;
    logic                       rr_q, rr_d, cmplt_q, cmplt_d, free, gnt, f;

    assign mode = {slv1_mode, slv0_mode};
    assign dv   = {slv1_data_valid, slv0_data_valid};
    assign pv   = {slv1_proc_val, slv0_proc_val};
    assign din  = {slv1_data, slv0_data};

    // Lane 0 is the MS lane and carries the earliest stream byte (index cnt).
    function automatic logic [DATA_WIDTH-1:0] proc_word(input logic [DATA_WIDTH-1:0] w,
        input logic [1:0] m, input logic [COLOR_SIZE-1:0] p, input logic [31:0] cnt,
        input logic [31:0] off);
        logic [COLOR_SIZE:0]   s;
        logic [32:0]           idx;
        logic [COLOR_SIZE-1:0] b;
        proc_word = w;
        for (int i = 0; i < LANES; i++) begin
            idx = {1'b0, cnt} + 33'(i);
            b   = w[DATA_WIDTH-1-i*COLOR_SIZE -: COLOR_SIZE];
            s   = (m == 2'b01) ? {1'b0, b} + {1'b0, p} : {1'b0, b} - {1'b0, p};
            if (idx >= 33'd16 && idx >= {1'b0, off} && (m == 2'b01 || m == 2'b10))
                proc_word[DATA_WIDTH-1-i*COLOR_SIZE -: COLOR_SIZE] =
                    s[COLOR_SIZE] ? {COLOR_SIZE{m == 2'b01}} : s[COLOR_SIZE-1:0];
        end
    endfunction

    // Header bytes 10..13 hold the little-endian pixel data offset.
    function automatic logic [31:0] cap_off(input logic [DATA_WIDTH-1:0] w,
        input logic [31:0] cnt, input logic [31:0] off);
        logic [32:0] idx;
        logic [1:0]  k;
        cap_off = off;
        for (int i = 0; i < LANES; i++) begin
            idx = {1'b0, cnt} + 33'(i);
            k   = idx[1:0] - 2'd2;
            if (idx >= 33'd10 && idx <= 33'd13)
                cap_off[{k, 3'b000} +: 8] = w[DATA_WIDTH-1-i*COLOR_SIZE -: 8];
        end
    endfunction

    always_comb begin
        free    = (valid_q == 2'b00) || mstr0_ready;
        gnt     = (dv == 2'b01) ? 1'b0 : (dv == 2'b10) ? 1'b1 : rr_q;
        rdy     = {~rst_n & free & gnt, ~rst_n & free & ~gnt};
        xfer    = dv & rdy;
        cnt_d   = cnt_q;
        off_d   = off_q;
        data_d  = data_q;
        valid_d = mstr0_ready ? 2'b00 : valid_q;
        rr_d    = rr_q;
        cmplt_d = 1'b0;
        if (|xfer) begin
            data_d     = proc_word(din[gnt], mode[gnt], pv[gnt], cnt_q[gnt], off_q[gnt]);
            valid_d    = gnt ? 2'b10 : 2'b01;
            rr_d       = ~gnt;
            off_d[gnt] = cap_off(din[gnt], cnt_q[gnt], off_q[gnt]);
            cnt_d[gnt] = (cnt_q[gnt] > 32'hFFFF_FFFF - 32'(LANES)) ? '1 : cnt_q[gnt] + 32'(LANES);
        end
        // A completion waits until that channel's word has left the output register.
        for (int c = 0; c < 2; c++) begin
            evt[c]  = (mode[c] == 2'b11) && (prev_q[c] != 2'b11);
            pend[c] = pend_q[c] | evt[c];
            ok[c]   = pend[c] && !(valid_q == 2'(c + 1) && !mstr0_ready);
        end
        pend_d = pend;
        f      = ~ok[0];
        if (|ok) begin
            cmplt_d   = 1'b1;
            pend_d[f] = 1'b0;
            cnt_d[f]  = '0;
            off_d[f]  = 32'd54;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q   <= '0;
            off_q   <= {32'd54, 32'd54};
            prev_q  <= '1;
            pend_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            rr_q    <= 1'b0;
            cmplt_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            prev_q  <= mode;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cmplt_q <= cmplt_d;
        end
    end

    assign slv0_ready       = rdy[0];
    assign slv1_ready       = rdy[1];
    assign mstr0_data       = data_q;
    assign mstr0_data_valid = valid_q;
    assign mstr0_cmplt      = cmplt_q;
endmodule

// File: tb/tb_image_processing_accelerator.sv
// tb_image_processing_accelerator: table-driven directed vectors on channel 0 plus
// hand-written backpressure, dual-channel arbitration and completion sequences.
module tb_image_processing_accelerator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  slv0_mode, slv1_mode;
    logic        slv0_data_valid, slv1_data_valid;
    logic [7:0]  slv0_proc_val, slv1_proc_val;
    logic [31:0] slv0_data, slv1_data;
    logic        slv0_ready, slv1_ready;
    logic        mstr0_cmplt, mstr0_ready;
    logic [31:0] mstr0_data;
    logic [1:0]  mstr0_data_valid;
    int          n_chk = 0;
    int          n_fail = 0;

    image_processing_accelerator #(.DATA_WIDTH(32), .COLOR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .slv0_mode(slv0_mode), .slv0_data_valid(slv0_data_valid), .slv0_proc_val(slv0_proc_val),
        .slv0_data(slv0_data), .slv0_ready(slv0_ready),
        .slv1_mode(slv1_mode), .slv1_data_valid(slv1_data_valid), .slv1_proc_val(slv1_proc_val),
        .slv1_data(slv1_data), .slv1_ready(slv1_ready),
        .mstr0_cmplt(mstr0_cmplt), .mstr0_ready(mstr0_ready),
        .mstr0_data(mstr0_data), .mstr0_data_valid(mstr0_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  p;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t v[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send0(input logic [1:0] m, input logic [7:0] p, input logic [31:0] d,
                         input logic [31:0] exp, input string name);
        int n = 0;
        slv0_mode = m;
        slv0_proc_val = p;
        slv0_data = d;
        slv0_data_valid = 1'b1;
        #1;
        while (!slv0_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: slv0_ready timeout", name);
        end
        @(posedge clk);
        #1 slv0_data_valid = 1'b0;
        @(negedge clk);
        chk({name, " data"}, mstr0_data, exp);
        chk({name, " valid"}, {30'd0, mstr0_data_valid}, 32'd1);
    endtask

    initial begin
        logic [1:0] code;
        v[0] = '{2'b10, 8'h0A, 32'h424D7E00, 32'h424D7E00};
        v[1] = '{2'b10, 8'h0A, 32'h00000000, 32'h00000000};
        v[2] = '{2'b10, 8'h0A, 32'h00003600, 32'h00003600};
        v[3] = '{2'b10, 8'h0A, 32'h00002800, 32'h00002800};
        for (int i = 4; i < 13; i++) v[i] = '{2'b10, 8'h0A, 32'h11223344, 32'h11223344};
        v[13] = '{2'b10, 8'h0A, 32'hAABBCCDD, 32'hAABBC2D3};
        v[14] = '{2'b10, 8'h0A, 32'h05FF0A80, 32'h00F50076};
        v[15] = '{2'b01, 8'h0A, 32'hF8000102, 32'hFF0A0B0C};
        v[16] = '{2'b00, 8'h0A, 32'hF8000102, 32'hF8000102};
        v[17] = '{2'b01, 8'hFF, 32'h01FF0080, 32'hFFFFFFFF};
        v[18] = '{2'b10, 8'hFF, 32'hFF000000, 32'h00000000};

        rst_n = 1'b1;
        mstr0_ready = 1'b1;
        slv0_mode = 2'b10; slv1_mode = 2'b00;
        slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
        slv0_proc_val = 8'h0A; slv1_proc_val = 8'h00;
        slv0_data = '0; slv1_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst slv0_ready", {31'd0, slv0_ready}, 32'd0);
        chk("rst slv1_ready", {31'd0, slv1_ready}, 32'd0);
        chk("rst data", mstr0_data, 32'd0);
        chk("rst valid", {30'd0, mstr0_data_valid}, 32'd0);
        chk("rst cmplt", {31'd0, mstr0_cmplt}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle slv0_ready", {31'd0, slv0_ready}, 32'd1);
        chk("idle slv1_ready", {31'd0, slv1_ready}, 32'd0);

        for (int i = 0; i < 19; i++) send0(v[i].mode, v[i].p, v[i].din, v[i].exp, $sformatf("vec%0d", i));

        // Backpressure: A is held while B waits, then B follows with no loss.
        send0(2'b00, 8'h00, 32'hCAFEBABE, 32'hCAFEBABE, "bp A");
        mstr0_ready = 1'b0;
        slv0_mode = 2'b01; slv0_proc_val = 8'h01; slv0_data = 32'h10203040; slv0_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp hold data", mstr0_data, 32'hCAFEBABE);
            chk("bp hold valid", {30'd0, mstr0_data_valid}, 32'd1);
            chk("bp slv0_ready", {31'd0, slv0_ready}, 32'd0);
        end
        mstr0_ready = 1'b1;
        #1 chk("bp release ready", {31'd0, slv0_ready}, 32'd1);
        @(posedge clk);
        #1 slv0_data_valid = 1'b0;
        @(negedge clk);
        chk("bp B data", mstr0_data, 32'h11213141);
        chk("bp B valid", {30'd0, mstr0_data_valid}, 32'd1);
        @(negedge clk);
        chk("bp drain valid", {30'd0, mstr0_data_valid}, 32'd0);

        // Dual channel: slv0 served last, so slv1 goes first and they alternate.
        slv0_mode = 2'b00; slv0_data = 32'hA0A0A0A0; slv0_data_valid = 1'b1;
        slv1_mode = 2'b00; slv1_data = 32'hB1B1B1B1; slv1_data_valid = 1'b1;
        code = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr valid", {30'd0, mstr0_data_valid}, {30'd0, code});
            chk("rr data", mstr0_data, code == 2'b01 ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            code = ~code;
        end
        slv0_mode = 2'b11;
        @(negedge clk);
        chk("cmplt pulse", {31'd0, mstr0_cmplt}, 32'd1);
        slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
        @(negedge clk);
        chk("cmplt single", {31'd0, mstr0_cmplt}, 32'd0);
        // Counter cleared: bytes 0..3 of the new frame are header and pass through.
        send0(2'b01, 8'h0A, 32'h01020304, 32'h01020304, "cnt cleared");

        slv0_mode = 2'b00; slv1_mode = 2'b00;
        repeat (2) @(negedge clk);
        slv0_mode = 2'b11; slv1_mode = 2'b11;
        @(negedge clk);
        chk("dual cmplt 1", {31'd0, mstr0_cmplt}, 32'd1);
        @(negedge clk);
        chk("dual cmplt 2", {31'd0, mstr0_cmplt}, 32'd1);
        @(negedge clk);
        chk("dual cmplt end", {31'd0, mstr0_cmplt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/image_processing_accelerator.md
Name: image_processing_accelerator

Overview:
Streaming per-pixel image processor for BMP byte streams. Two slave input channels (slv0, slv1) each carry a packed word stream plus a per-channel operation mode and operand. Words are processed byte-wise and forwarded on a single master output channel. Header bytes pass through unmodified, and a completion pulse marks end-of-frame.

Parameters:
DATA_WIDTH, 32, width of the data bus in bits; must be a multiple of COLOR_SIZE.
COLOR_SIZE, 8, width of one colour byte (lane) and of proc_val.

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  reset. The name is kept per codebase. It is synchronous and active-high: the DUT is in reset when rst_n=1 at a clk edge.
slv0_mode  input  2  operation for channel 0
slv0_data_valid  input  1  channel 0 word valid
slv0_proc_val  input  COLOR_SIZE  operand for channel 0
slv0_data  input  DATA_WIDTH  channel 0 word; earliest stream byte in MS lane [DATA_WIDTH-1 -: COLOR_SIZE]
slv0_ready  output  1  channel 0 can accept
slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data, slv1_ready  same as channel 0, for channel 1
mstr0_cmplt  output  1  one-cycle end-of-frame pulse
mstr0_ready  input  1  downstream accepts output
mstr0_data  output  DATA_WIDTH  processed word
mstr0_data_valid  output  2  00 none, 01 word from slv0, 10 word from slv1, 11 never driven

Behaviour:
- Reset values (clk edge with rst_n=1):
  - slvX_ready=0, mstr0_data=0, mstr0_data_valid=00, mstr0_cmplt=0.
  - Byte counters=0, data offsets=54, round-robin pointer=slv0.
  - Reset mid-frame discards the held word and all counters.
- Modes, applied to each pixel byte with operand P=slvX_proc_val, sampled with the word:
  - 00 pass-through.
  - 01 saturating add: min(b+P, 2^COLOR_SIZE-1).
  - 10 saturating subtract: max(b-P, 0).
  - 11 end-of-frame: a word accepted in this mode passes unmodified.
- Header handling:
  - Each channel keeps a 32-bit byte counter of accepted stream bytes (+DATA_WIDTH/COLOR_SIZE per accepted word, saturating).
  - Bytes 10..13 (little-endian) are captured as that channel's data offset once received.
  - Any byte with index < 16 or < current offset passes unmodified, regardless of mode.
- Output register is one word deep. Output is free when mstr0_data_valid==00 or mstr0_ready==1.
- Handshake:
  - slvX_ready = not in reset AND output free AND channel X granted.
  - A word transfers on the edge where slvX_data_valid & slvX_ready.
  - Its processed value appears on mstr0_data with mstr0_data_valid set the next cycle (latency 1).
  - Output is held stable until mstr0_ready=1. With no new transfer it then clears to 00 after one cycle.
- Arbitration:
  - If only one channel is valid, it is granted.
  - If both are valid, round-robin: the channel not served last is granted.
  - Ready is asserted only toward the granted channel; the other's ready is 0.
  - With mstr0_ready held 1 and one active channel, throughput is one word per cycle.
- Completion:
  - When a channel's mode goes from non-11 to 11, mstr0_cmplt pulses high for exactly one cycle.
  - The pulse occurs once no word from that channel is pending in the output register, either the same edge or after drain.
  - The same event clears that channel's byte counter and restores its offset to 54.
  - Simultaneous events on both channels give two pulses on consecutive cycles.
- mstr0_ready=0 stalls: slvX_ready drop combinationally in the same cycle and no word is lost or duplicated.

Test Plan:
- Reset then idle: rst_n=1 for 2 cycles, then 0 -> all outputs 0 in reset; slv0_ready=1 the cycle after release with mstr0_ready=1.
- Header pass-through, mode 10, P=0x0A: words 0x424D7E00, 0x00000000, 0x00003600, 0x00002800 -> output words identical, valid=01, latency 1; offset captured as 54.
- Pixel subtract, mode 10, P=0x0A, byte index >= 54: 0x05FF0A80 -> 0x00F50076.
- Pixel add, mode 01, P=0x0A: 0xF8000102 -> 0xFF0A0B0C; mode 00 -> unchanged.
- Backpressure: mstr0_ready=0 for 3 cycles with slv0 valid -> mstr0_data held, slv0_ready=0; on release the next word follows with no loss.
- Dual channel, both valid continuously -> mstr0_data_valid alternates 01, 10, 01 ...; then slv0_mode -> 11 -> mstr0_cmplt high exactly one cycle and channel 0 counter cleared.
